// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined floating-point comparator with valid/ready handshake,
// operand class flags and a sticky invalid flag. Define FP_CMP_MINMAX_EN to add min_out/max_out.
module fp_cmp_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt,
  output logic         unordered,
  output logic         nan,
  output logic         snan,
  output logic         inf,
  output logic         subnormal,
  output logic         sticky_invalid,
  input  logic         sticky_clr
`ifdef FP_CMP_MINMAX_EN
  ,
  output logic [W-1:0] min_out,
  output logic [W-1:0] max_out
`endif
);

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
    logic snan;
  } cls_t;

  typedef struct packed {
    logic any_nan;
    logic any_snan;
    logic any_inf;
    logic any_sub;
    logic both_zero;
    logic sign_x;
    logic sign_y;
    logic mag_lt;
    logic mag_eq;
`ifdef FP_CMP_MINMAX_EN
    logic         nan_x;
    logic         nan_y;
    logic         x_le_y;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
`endif
  } s1_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic unordered;
    logic nan;
    logic snan;
    logic inf;
    logic subnormal;
  } s2_t;

  function automatic cls_t classify(input logic [W-1:0] v);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    cls_t             c;
    e      = v[W-2:MAN_W];
    m      = v[MAN_W-1:0];
    c.zero = (e == '0) && (m == '0);
    c.sub  = (e == '0) && (m != '0);
    c.inf  = (e == '1) && (m == '0);
    c.nan  = (e == '1) && (m != '0);
    c.snan = c.nan && !m[MAN_W-1];
    return c;
  endfunction

  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic sticky_q, sticky_d;
  logic s2_ready, in_xfer, s2_load;
  cls_t cls_x, cls_y;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_ready;
    in_xfer  = in_valid && in_ready;
    s2_load  = vld_p1_q && s2_ready;
    vld_p1_d = in_xfer || (vld_p1_q && !s2_ready);
    vld_p2_d = s2_load || (vld_p2_q && !out_ready);
    // A new snan result arriving in S2 outranks a simultaneous clear.
    sticky_d = (s2_load && s1_q.any_snan) || (sticky_q && !sticky_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      sticky_q <= 1'b0;
      s2_q     <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      sticky_q <= sticky_d;
      s2_q     <= s2_d;
    end
  end

  // ---- Stage 1: operand classification and field compares ----
  always_comb begin
    cls_x = classify(x);
    cls_y = classify(y);
    s1_d  = s1_q;
    if (in_xfer) begin
      s1_d.any_nan   = cls_x.nan  || cls_y.nan;
      s1_d.any_snan  = cls_x.snan || cls_y.snan;
      s1_d.any_inf   = cls_x.inf  || cls_y.inf;
      s1_d.any_sub   = cls_x.sub  || cls_y.sub;
      s1_d.both_zero = cls_x.zero && cls_y.zero;
      s1_d.sign_x    = x[W-1];
      s1_d.sign_y    = y[W-1];
      s1_d.mag_lt    = x[W-2:0] <  y[W-2:0];
      s1_d.mag_eq    = x[W-2:0] == y[W-2:0];
`ifdef FP_CMP_MINMAX_EN
      s1_d.nan_x     = cls_x.nan;
      s1_d.nan_y     = cls_y.nan;
      // Total order for min/max: sign first, so -0 sorts below +0.
      if (x[W-1] != y[W-1])
        s1_d.x_le_y  = x[W-1];
      else if (x[W-1])
        s1_d.x_le_y  = !(x[W-2:0] < y[W-2:0]);
      else
        s1_d.x_le_y  = x[W-2:0] <= y[W-2:0];
      s1_d.xv        = x;
      s1_d.yv        = y;
`endif
    end
  end

  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  // ---- Stage 2: final ordering and class flags ----
  always_comb begin
    s2_d = s2_q;
    if (s2_load) begin
      s2_d           = '0;
      s2_d.nan       = s1_q.any_nan;
      s2_d.snan      = s1_q.any_snan;
      s2_d.inf       = s1_q.any_inf;
      s2_d.subnormal = s1_q.any_sub;
      if (s1_q.any_nan)
        s2_d.unordered = 1'b1;
      else if (s1_q.both_zero)
        s2_d.eq = 1'b1;
      else if (s1_q.sign_x != s1_q.sign_y) begin
        s2_d.lt = s1_q.sign_x;
        s2_d.gt = !s1_q.sign_x;
      end else if (s1_q.mag_eq)
        s2_d.eq = 1'b1;
      else if (s1_q.mag_lt ^ s1_q.sign_x)
        s2_d.lt = 1'b1;
      else
        s2_d.gt = 1'b1;
    end
  end

`ifdef FP_CMP_MINMAX_EN
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

  logic [W-1:0] min_p2_q, min_p2_d;
  logic [W-1:0] max_p2_q, max_p2_d;

  always_comb begin
    min_p2_d = min_p2_q;
    max_p2_d = max_p2_q;
    if (s2_load) begin
      if (s1_q.nan_x && s1_q.nan_y) begin
        min_p2_d = QNAN;
        max_p2_d = QNAN;
      end else if (s1_q.nan_x) begin
        min_p2_d = s1_q.yv;
        max_p2_d = s1_q.yv;
      end else if (s1_q.nan_y) begin
        min_p2_d = s1_q.xv;
        max_p2_d = s1_q.xv;
      end else if (s1_q.x_le_y) begin
        min_p2_d = s1_q.xv;
        max_p2_d = s1_q.yv;
      end else begin
        min_p2_d = s1_q.yv;
        max_p2_d = s1_q.xv;
      end
    end
  end

  always_ff @(posedge clk) begin
    min_p2_q <= min_p2_d;
    max_p2_q <= max_p2_d;
  end

  assign min_out = min_p2_q;
  assign max_out = max_p2_q;
`endif

  assign out_valid      = vld_p2_q;
  assign sticky_invalid = sticky_q;
  assign {lt, eq, gt, unordered, nan, snan, inf, subnormal} = s2_q;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Bench for fp_cmp_pipe at half precision: directed scenarios plus a randomized
// stream checked against a real-valued reference model.
module tb_fp_cmp_pipe;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 16;
  localparam int BIAS  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, in_valid, in_ready, out_valid, out_ready, sticky_clr;
  logic lt, eq, gt, unordered, nan, snan, inf, subnormal, sticky_invalid;
  logic [W-1:0] x, y;
`ifdef FP_CMP_MINMAX_EN
  logic [W-1:0] min_out, max_out;
`endif
  logic [7:0] flags;
  assign flags = {lt, eq, gt, unordered, nan, snan, inf, subnormal};

  int total = 0;
  int bad   = 0;

  fp_cmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .lt(lt), .eq(eq), .gt(gt), .unordered(unordered),
    .nan(nan), .snan(snan), .inf(inf), .subnormal(subnormal),
    .sticky_invalid(sticky_invalid), .sticky_clr(sticky_clr)
`ifdef FP_CMP_MINMAX_EN
    , .min_out(min_out), .max_out(max_out)
`endif
  );

  // ---------------- reference model ----------------
  function automatic real to_real(input logic [W-1:0] v);
    int  e, m, sh;
    real mag;
    e = int'(v[14:10]);
    m = int'(v[9:0]);
    if (e == 31) mag = 1.0e300;
    else begin
      if (e == 0) begin mag = real'(m); sh = 1 - BIAS - MAN_W; end
      else begin mag = real'(m + 1024); sh = e - BIAS - MAN_W; end
      for (int i = 0; i < sh; i++) mag = mag * 2.0;
      for (int i = 0; i > sh; i--) mag = mag / 2.0;
    end
    return v[15] ? -mag : mag;
  endfunction

  function automatic bit is_nan(input logic [W-1:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h0);
  endfunction

  function automatic logic [7:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0] c;
    logic n, s, i, sb;
    real va, vb;
    n  = is_nan(a) || is_nan(b);
    s  = (is_nan(a) && !a[9]) || (is_nan(b) && !b[9]);
    i  = (a[14:0] == 15'h7C00) || (b[14:0] == 15'h7C00);
    sb = (a[14:10] == 5'h0 && a[9:0] != 10'h0) || (b[14:10] == 5'h0 && b[9:0] != 10'h0);
    va = to_real(a);
    vb = to_real(b);
    if (n) c = 4'b0001;
    else if (va < vb) c = 4'b1000;
    else if (va == vb) c = 4'b0100;
    else c = 4'b0010;
    return {c, n, s, i, sb};
  endfunction

`ifdef FP_CMP_MINMAX_EN
  function automatic logic [W-1:0] ref_min(input logic [W-1:0] a, input logic [W-1:0] b);
    if (is_nan(a) && is_nan(b)) return 16'h7E00;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    if (to_real(a) < to_real(b)) return a;
    if (to_real(b) < to_real(a)) return b;
    return (a[15] || !b[15]) ? a : b;
  endfunction

  function automatic logic [W-1:0] ref_max(input logic [W-1:0] a, input logic [W-1:0] b);
    if (is_nan(a) && is_nan(b)) return 16'h7E00;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    if (to_real(a) > to_real(b)) return a;
    if (to_real(b) > to_real(a)) return b;
    return (!a[15] || b[15]) ? a : b;
  endfunction
`endif

  function automatic logic [W-1:0] gen_op();
    logic [W-1:0] r;
    r = 16'($urandom);
    case ($urandom_range(7))
      0: r = {r[15], 15'h0};
      1: r = {r[15], 5'h1F, 10'h0};
      2: r = {r[15], 5'h1F, 1'b1, r[8:0]};
      3: r = {r[15], 5'h1F, 1'b0, r[8:0] | 9'h1};
      4: r = {r[15], 5'h0, r[9:0] | 10'h1};
      default: ;
    endcase
    return r;
  endfunction

  // Drives one pair with out_ready high and returns #1 after the result edge.
  task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; x = a; y = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL reset_flags got=%h want=00", flags); end
    total++; if (sticky_invalid !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", sticky_invalid); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic_latency();
    @(posedge clk); #1;
    in_valid = 1'b1; x = 16'h3C00; y = 16'h4000; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_cycle1 out_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_cycle2 out_valid got=%b want=1", out_valid); end
    total++; if (flags !== 8'h80) begin bad++; $display("FAIL one_lt_two flags got=%h want=80", flags); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_no_dup out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_signed_zero();
    drive_pair(16'h8000, 16'h0000);
    total++; if (flags !== 8'h40) begin bad++; $display("FAIL zero_eq flags got=%h want=40", flags); end
`ifdef FP_CMP_MINMAX_EN
    total++; if (min_out !== 16'h8000) begin bad++; $display("FAIL zero_min got=%h want=8000", min_out); end
    total++; if (max_out !== 16'h0000) begin bad++; $display("FAIL zero_max got=%h want=0000", max_out); end
`endif
  endtask

  task automatic test_snan_sticky();
    drive_pair(16'h7D00, 16'h3C00);
    total++; if (flags !== 8'h1C) begin bad++; $display("FAIL snan_flags got=%h want=1c", flags); end
    total++; if (sticky_invalid !== 1'b1) begin bad++; $display("FAIL snan_sticky_set got=%b want=1", sticky_invalid); end
`ifdef FP_CMP_MINMAX_EN
    total++; if (min_out !== 16'h3C00) begin bad++; $display("FAIL snan_min got=%h want=3c00", min_out); end
    total++; if (max_out !== 16'h3C00) begin bad++; $display("FAIL snan_max got=%h want=3c00", max_out); end
`endif
    drive_pair(16'h4000, 16'h3C00);
    total++; if (flags !== 8'h20) begin bad++; $display("FAIL two_gt_one flags got=%h want=20", flags); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (sticky_invalid !== 1'b1) begin bad++; $display("FAIL sticky_hold got=%b want=1", sticky_invalid); end
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    total++; if (sticky_invalid !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", sticky_invalid); end
  endtask

  task automatic test_inf_subnormal();
    drive_pair(16'hFC00, 16'h8001);
    total++; if (flags !== 8'h83) begin bad++; $display("FAIL ninf_vs_nsub flags got=%h want=83", flags); end
  endtask

  task automatic test_sticky_set_wins();
    @(posedge clk); #1;
    in_valid = 1'b1; x = 16'h7D00; y = 16'h0000; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    total++; if (sticky_invalid !== 1'b1) begin bad++; $display("FAIL set_wins sticky got=%b want=1", sticky_invalid); end
    total++; if (flags !== 8'h1C) begin bad++; $display("FAIL set_wins flags got=%h want=1c", flags); end
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    total++; if (sticky_invalid !== 1'b0) begin bad++; $display("FAIL set_wins_clear got=%b want=0", sticky_invalid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] px [4];
    logic [W-1:0] py [4];
    logic [7:0]   ef;
    int sent, got;
    bit saw_stall;
    px = '{16'h3C00, 16'h4000, 16'h8000, 16'h7E00};
    py = '{16'h4000, 16'h3C00, 16'h0000, 16'h0000};
    sent = 0; got = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(posedge clk); #1;
      in_valid = (sent < 4);
      if (sent < 4) begin x = px[sent]; y = py[sent]; end
      out_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        total++;
        if (got >= 4) begin bad++; $display("FAIL b2b_extra_result got=%0d want<4", got); end
        else begin
          ef = ref_flags(px[got], py[got]);
          if (flags !== ef) begin bad++; $display("FAIL b2b_flags idx=%0d got=%h want=%h", got, flags, ef); end
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (saw_stall !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_stall got=%b want=1", saw_stall); end
    total++; if (got != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    in_valid = 1'b1; x = 16'h7D00; y = 16'h3C00; out_ready = 1'b0;
    @(posedge clk); #1;
    x = 16'h3C00; y = 16'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (sticky_invalid !== 1'b1) begin bad++; $display("FAIL midrst_pre_sticky got=%b want=1", sticky_invalid); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    total++; if (sticky_invalid !== 1'b0) begin bad++; $display("FAIL midrst_sticky got=%b want=0", sticky_invalid); end
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL midrst_flags got=%h want=00", flags); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output cyc=%0d got=%b want=0", i, out_valid); end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; x = 16'h4000; y = 16'h3C00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_lat1 got=%b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_lat2 got=%b want=1", out_valid); end
    total++; if (flags !== 8'h20) begin bad++; $display("FAIL midrst_flags_after got=%h want=20", flags); end
  endtask

  task automatic test_random(input int n, input int pv, input int pr);
    logic [W-1:0] qx[$];
    logic [W-1:0] qy[$];
    logic [W-1:0] cx, cy, ex, ey;
    logic [7:0]   ef;
    logic         sticky_m, exp_rdy;
    int sent, got, cyc;
    bit offering;
    sent = 0; got = 0; cyc = 0; offering = 1'b0; sticky_m = 1'b0;
    cx = '0; cy = '0;
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    while ((sent < n || got < sent) && cyc < n * 20) begin
      @(posedge clk); #1;
      if (!offering && sent < n && $urandom_range(99) < pv) begin
        cx = gen_op();
        case ($urandom_range(3))
          0: cy = cx;
          1: cy = {~cx[15], cx[14:0]};
          default: cy = gen_op();
        endcase
        offering = 1'b1;
      end
      in_valid = offering; x = cx; y = cy;
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      exp_rdy = ((sent - got) < 2) || out_ready;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready inflight=%0d got=%b want=%b", sent - got, in_ready, exp_rdy); end
      if (out_valid && out_ready) begin
        total++;
        if (qx.size() == 0) begin bad++; $display("FAIL rnd_unexpected_output got=1 want=0"); end
        else begin
          ex = qx.pop_front(); ey = qy.pop_front();
          ef = ref_flags(ex, ey);
          if (flags !== ef) begin bad++; $display("FAIL rnd_flags x=%h y=%h got=%h want=%h", ex, ey, flags, ef); end
          sticky_m = sticky_m | ef[2];
          total++; if (sticky_invalid !== sticky_m) begin bad++; $display("FAIL rnd_sticky x=%h y=%h got=%b want=%b", ex, ey, sticky_invalid, sticky_m); end
`ifdef FP_CMP_MINMAX_EN
          total++; if (min_out !== ref_min(ex, ey)) begin bad++; $display("FAIL rnd_min x=%h y=%h got=%h want=%h", ex, ey, min_out, ref_min(ex, ey)); end
          total++; if (max_out !== ref_max(ex, ey)) begin bad++; $display("FAIL rnd_max x=%h y=%h got=%h want=%h", ex, ey, max_out, ref_max(ex, ey)); end
`endif
          got++;
        end
      end
      if (in_valid && in_ready) begin
        qx.push_back(cx); qy.push_back(cy);
        sent++; offering = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != n) begin bad++; $display("FAIL rnd_timeout delivered=%0d want=%0d", got, n); end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_signed_zero();
    test_snan_sticky();
    test_inf_subnormal();
    test_sticky_set_wins();
    test_back_to_back();
    test_reset_midflight();
    test_random(300, 70, 60);
    test_random(200, 100, 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_cmp_pipe.md
FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width (valid range 2..11).
REQ-002 Parameter MAN_W, default 10, mantissa field width (valid range 1..52); operand width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair x,y offered.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 x, y  input  W each  operands {sign, exponent, mantissa}.
REQ-008 out_valid  output  1  result flags valid.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 lt, eq, gt, unordered  output  1 each  ordered comparison result of x vs y.
REQ-011 nan, snan, inf, subnormal  output  1 each  class flags, OR over both operands.
REQ-012 sticky_invalid  output  1  set when any accepted pair contains a signalling NaN.
REQ-013 sticky_clr  input  1  clears sticky_invalid.

Function
REQ-014 Handshake: transfer on in_valid&in_ready and on out_valid&out_ready; x, y are sampled only on an input transfer.
REQ-015 Pipeline: two registered stages; S1 registers operand classification and field compares, S2 registers final flags; latency is exactly 2 cycles when out_ready stays high.
REQ-016 Throughput: one pair per cycle with out_ready high; in_ready = ~S1_valid | ~S2_valid | out_ready.
REQ-017 Back-pressure: when out_valid&~out_ready, S2 holds its flags unchanged; S1 advances into S2 only when S2 is empty or draining; no pair is dropped or duplicated.
REQ-018 Classification per operand: zero = exp==0 & man==0; subnormal = exp==0 & man!=0; inf = exp all-ones & man==0; nan = exp all-ones & man!=0; snan = nan & man MSB==0.
REQ-019 When either operand is NaN: unordered=1 and lt=eq=gt=0.
REQ-020 Otherwise unordered=0 and exactly one of lt, eq, gt is 1.
REQ-021 +0 and -0 compare equal (eq=1) regardless of sign.
REQ-022 Ordering: opposite signs (non-zero) -> positive is greater; same sign -> magnitude compare (exponent, then mantissa), inverted when both negative.
REQ-023 Infinities order as the largest magnitudes; +inf vs +inf gives eq=1.
REQ-024 Subnormals compare by raw magnitude; no flushing.
REQ-025 sticky_invalid sets in the cycle the snan-carrying pair reaches S2 and stays set until sticky_clr or reset.
REQ-026 sticky_clr coincident with a new snan result: set wins (sticky_invalid=1 next cycle).

Reset
REQ-027 On a clk edge with reset_n=0: S1/S2 valid cleared, out_valid=0, all result and class flags=0, sticky_invalid=0.
REQ-028 in_ready=1 in the first cycle after reset_n returns high.
REQ-029 Reset asserted mid-operation discards all in-flight pairs; no out_valid for them after release.

Configuration
REQ-030 Macro FP_CMP_MINMAX_EN defined: additional outputs min_out and max_out (W bits each) registered in S2 alongside the flags, holding IEEE 754-2019 minimumNumber/maximumNumber semantics: a single NaN operand returns the other operand; two NaNs return the canonical quiet NaN (exp all-ones, man MSB=1, rest 0, sign 0); -0 is treated as less than +0 for min/max only.
REQ-031 Macro FP_CMP_MINMAX_EN undefined: min_out and max_out ports are absent and no min/max logic is built; all other behaviour is unchanged.

Verification (default parameters, half precision)
REQ-032 x=0x3C00 (1.0), y=0x4000 (2.0), out_ready=1 -> 2 cycles later out_valid=1, lt=1, eq=gt=unordered=0.
REQ-033 x=0x8000, y=0x0000 -> eq=1, lt=gt=0; with FP_CMP_MINMAX_EN, min_out=0x8000, max_out=0x0000.
REQ-034 x=0x7D00 (sNaN), y=0x3C00 -> unordered=1, nan=1, snan=1, sticky_invalid=1 and held until sticky_clr pulse; with FP_CMP_MINMAX_EN, min_out=max_out=0x3C00.
REQ-035 Stream 4 pairs back-to-back, out_ready low for cycles 2-4 -> in_ready deasserts once both stages full, all 4 results emerge in order, none lost.
REQ-036 x=0xFC00 (-inf), y=0x8001 (negative subnormal) -> lt=1, inf=1, subnormal=1.
REQ-037 Assert reset_n=0 for one cycle with 2 pairs in flight -> out_valid=0 and sticky_invalid=0 after release; next pair returns with 2-cycle latency.
